// File: rtl/pcapng_epb_framer.sv
// Purpose : wraps each captured frame (timestamp beat, length beat, data) into a pcapng Enhanced Packet Block.
// Latency : length beat accepted in cycle n -> HDR0 valid in n+1; then one output word per input data word.
// Backpress: s_axis_tready is 1 in IDLE/LEN, follows output-register space in DATA, and is 0 while headers/trailer are emitted.
//
// Ports:
//   axi_clk, axi_rstn            clock, synchronous active-low reset
//   s_axis_*                     capture stream in (tdata/tkeep/tvalid/tready/tlast/tuser)
//   m_axis_*                     EPB byte stream out, little-endian 64-bit words
//   length_error                 one-cycle pulse: runt frame or data byte count != captured length
//   block_count                  number of EPBs whose final word has been accepted (wraps)
module pcapng_epb_framer #(
    parameter int INTERFACE_ID    = 0,
    parameter int FRAME_LEN_WIDTH = 16
) (
    input  logic        axi_clk,
    input  logic        axi_rstn,
    input  logic [63:0] s_axis_tdata,
    input  logic [7:0]  s_axis_tkeep,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    output logic [63:0] m_axis_tdata,
    output logic [7:0]  m_axis_tkeep,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic        length_error,
    output logic [31:0] block_count
);

    typedef enum logic [2:0] {IDLE, LEN, HDR0, HDR1, HDR2, DATA, TAIL} state_t;

    state_t      state;
    logic [63:0] ts64;
    logic [31:0] cap;
    logic [31:0] total;
    logic [31:0] carry;      // upper half of the previous input beat, emitted in the next output word
    logic [31:0] byte_cnt;   // data bytes received so far in this frame
    logic        tail_wide;  // last input beat had more than 4 bytes: trailer shares a word with data
    logic        bad;

    logic        out_free;
    logic        m_fire;
    logic        s_fire;
    logic [31:0] cap_in;
    logic [31:0] total_in;
    logic [63:0] in_mask;
    logic [63:0] in_m;
    logic [3:0]  beat_bytes;
    logic [31:0] byte_sum;

    function automatic logic [3:0] keep_count(input logic [7:0] k);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'd0, k[i]};
        end
        return c;
    endfunction

    assign out_free = !m_axis_tvalid || m_axis_tready;
    assign m_fire   = m_axis_tvalid && m_axis_tready;
    assign s_fire   = s_axis_tvalid && s_axis_tready;
    assign cap_in   = 32'(s_axis_tdata[FRAME_LEN_WIDTH-1:0]);
    // 28 header bytes + 4 trailer bytes + cap rounded up to a multiple of 4
    assign total_in = (cap_in + 32'd35) & ~32'd3;

    // Bytes beyond tkeep on the last beat are forced to zero so they double as pad bytes.
    always_comb begin
        in_mask = '1;
        for (int i = 0; i < 8; i++) begin
            in_mask[8*i +: 8] = {8{!s_axis_tlast || s_axis_tkeep[i]}};
        end
    end

    assign in_m       = s_axis_tdata & in_mask;
    assign beat_bytes = s_axis_tlast ? keep_count(s_axis_tkeep) : 4'd8;
    assign byte_sum   = byte_cnt + 32'(beat_bytes);

    always_comb begin
        s_axis_tready = 1'b0;
        case (state)
            IDLE, LEN: s_axis_tready = 1'b1;
            DATA:      s_axis_tready = out_free;
            default:   s_axis_tready = 1'b0;
        endcase
    end

    always_ff @(posedge axi_clk) begin
        if (!axi_rstn) begin
            state         <= IDLE;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
            length_error  <= 1'b0;
            block_count   <= '0;
            ts64          <= '0;
            cap           <= '0;
            total         <= '0;
            carry         <= '0;
            byte_cnt      <= '0;
            tail_wide     <= 1'b0;
            bad           <= 1'b0;
        end else begin
            length_error <= 1'b0;
            if (m_fire) begin
                m_axis_tvalid <= 1'b0;
                m_axis_tlast  <= 1'b0;
                m_axis_tuser  <= 1'b0;
                if (m_axis_tlast) begin
                    block_count <= block_count + 32'd1;
                end
            end

            case (state)
                IDLE: begin
                    if (s_fire) begin
                        if (s_axis_tlast) begin
                            length_error <= 1'b1;
                        end else begin
                            ts64  <= 64'(s_axis_tdata[31:0]) * 64'd1000000000 + 64'(s_axis_tdata[63:32]);
                            state <= LEN;
                        end
                    end
                end
                LEN: begin
                    if (s_fire) begin
                        if (s_axis_tlast) begin
                            length_error <= 1'b1;
                            state        <= IDLE;
                        end else begin
                            cap           <= cap_in;
                            total         <= total_in;
                            carry         <= cap_in;  // original-length field leads the first data word
                            byte_cnt      <= '0;
                            m_axis_tdata  <= {total_in, 32'h0000_0006};
                            m_axis_tkeep  <= 8'hFF;
                            m_axis_tvalid <= 1'b1;
                            state         <= HDR0;
                        end
                    end
                end
                HDR0: begin
                    if (m_fire) begin
                        m_axis_tdata  <= {ts64[63:32], 32'(INTERFACE_ID)};
                        m_axis_tvalid <= 1'b1;
                        state         <= HDR1;
                    end
                end
                HDR1: begin
                    if (m_fire) begin
                        m_axis_tdata  <= {cap, ts64[31:0]};
                        m_axis_tvalid <= 1'b1;
                        state         <= HDR2;
                    end
                end
                HDR2: begin
                    if (m_fire) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (s_fire) begin
                        m_axis_tdata  <= {in_m[31:0], carry};
                        m_axis_tkeep  <= 8'hFF;
                        m_axis_tvalid <= 1'b1;
                        carry         <= in_m[63:32];
                        byte_cnt      <= byte_sum;
                        if (s_axis_tlast) begin
                            tail_wide <= (beat_bytes > 4'd4);
                            bad       <= s_axis_tuser;
                            if (byte_sum != cap) begin
                                length_error <= 1'b1;
                            end
                            state <= TAIL;
                        end
                    end
                end
                TAIL: begin
                    // Entered with the last data word pending; the trailer word follows its acceptance.
                    if (m_fire) begin
                        if (m_axis_tlast) begin
                            state <= IDLE;
                        end else begin
                            m_axis_tvalid <= 1'b1;
                            m_axis_tlast  <= 1'b1;
                            m_axis_tuser  <= bad;
                            if (tail_wide) begin
                                m_axis_tdata <= {total, carry};
                                m_axis_tkeep <= 8'hFF;
                            end else begin
                                m_axis_tdata <= {32'h0, total};
                                m_axis_tkeep <= 8'h0F;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pcapng_epb_framer.sv
// Purpose : self-checking bench for pcapng_epb_framer (byte-level EPB model feeding a scoreboard).
// Latency : checks HDR0/HDR1 timing relative to the length beat and gap-free DATA streaming.
// Backpress: m_axis_tready is either held high or randomised per cycle; held output must stay stable.
module tb_pcapng_epb_framer;

    logic        axi_clk = 1'b0;
    logic        axi_rstn = 1'b0;
    logic [63:0] s_axis_tdata = '0;
    logic [7:0]  s_axis_tkeep = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tuser = 1'b0;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic        length_error;
    logic [31:0] block_count;

    pcapng_epb_framer #(.INTERFACE_ID(0), .FRAME_LEN_WIDTH(16)) dut (
        .axi_clk(axi_clk), .axi_rstn(axi_rstn),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .length_error(length_error), .block_count(block_count)
    );

    always #5 axi_clk = ~axi_clk;

    typedef struct {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        logic        u;
    } word_t;

    typedef struct {
        logic [31:0] nbytes;
        logic [31:0] cap;
        logic [31:0] sec;
        logic [31:0] nsec;
        bit          bad;
        bit          rnd;
        logic [31:0] exp_total;
        int          exp_words;
        int          exp_lerr;
    } vec_t;

    word_t       sbq[$];
    logic [7:0]  cur[$];
    logic [7:0]  mb[$];

    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    bit          rand_rdy = 0;
    bit          sb_en = 1;
    bit          chk_gap = 0;
    int          gap_bad = 0;
    int          lerr_cnt = 0;
    int          words_seen = 0;
    int          tlast_seen = 0;
    int          mon_idx = 0;
    int          blk_words = 0;
    int          beat1_cyc = 0;
    int          hdr0_cyc = 0;
    int          hdr1_cyc = 0;
    int          d0_cyc = 0;
    logic [63:0] hdr [3];
    logic [63:0] fin_dat;
    logic [7:0]  fin_keep;
    logic        fin_user;
    bit          have_hold = 0;
    word_t       hold;

    always @(posedge axi_clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(posedge axi_clk);
            #1;
            m_axis_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Output monitor: scoreboard compare, stall stability, per-block bookkeeping.
    always @(negedge axi_clk) begin
        if (!axi_rstn) begin
            mon_idx   = 0;
            have_hold = 0;
        end else begin
            if (length_error) lerr_cnt++;
            if (have_hold) begin
                check("stall_hold", {m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tkeep, m_axis_tdata},
                      {1'b1, hold.l, hold.u, hold.k, hold.d});
            end
            have_hold = m_axis_tvalid && !m_axis_tready;
            hold.d = m_axis_tdata; hold.k = m_axis_tkeep; hold.l = m_axis_tlast; hold.u = m_axis_tuser;
            if (m_axis_tvalid && m_axis_tready) begin
                word_t e;
                words_seen++;
                if (mon_idx < 3) hdr[mon_idx] = m_axis_tdata;
                if (mon_idx == 0) hdr0_cyc = cyc;
                if (mon_idx == 1) hdr1_cyc = cyc;
                if (mon_idx == 3) d0_cyc = cyc;
                if (sb_en) begin
                    if (sbq.size() == 0) begin
                        check("sb_unexpected_word", m_axis_tdata, 64'hx);
                    end else begin
                        e = sbq.pop_front();
                        check("sb_word", {m_axis_tlast, m_axis_tuser, m_axis_tkeep, m_axis_tdata},
                              {e.l, e.u, e.k, e.d});
                    end
                end
                if (m_axis_tlast) begin
                    tlast_seen++;
                    blk_words = mon_idx + 1;
                    fin_dat   = m_axis_tdata;
                    fin_keep  = m_axis_tkeep;
                    fin_user  = m_axis_tuser;
                    if (chk_gap && (cyc - d0_cyc) != (mon_idx - 3)) gap_bad++;
                    mon_idx = 0;
                end else begin
                    mon_idx++;
                end
            end
        end
    end

    task automatic put32(input logic [31:0] v);
        for (int j = 0; j < 4; j++) mb.push_back(v[8*j +: 8]);
    endtask

    // Reference EPB: build the byte stream, then cut into 64-bit words.
    task automatic model_push(input logic [31:0] sec, input logic [31:0] nsec, input logic [31:0] cap, input bit bad);
        logic [31:0] tot;
        logic [63:0] ts;
        int          pad;
        word_t       w;
        tot = 32'd32 + cap + ((32'd4 - cap % 32'd4) % 32'd4);
        ts  = {32'h0, sec} * 64'd1000000000 + {32'h0, nsec};
        mb.delete();
        put32(32'h6); put32(tot); put32(32'h0); put32(ts[63:32]); put32(ts[31:0]); put32(cap); put32(cap);
        foreach (cur[i]) mb.push_back(cur[i]);
        pad = (4 - cur.size() % 4) % 4;
        for (int i = 0; i < pad; i++) mb.push_back(8'h00);
        put32(tot);
        for (int i = 0; i < mb.size(); i += 8) begin
            int r;
            r = (mb.size() - i >= 8) ? 8 : mb.size() - i;
            w.d = '0;
            for (int j = 0; j < r; j++) w.d[8*j +: 8] = mb[i+j];
            w.k = (r == 8) ? 8'hFF : 8'h0F;
            w.l = (i + 8 >= mb.size());
            w.u = w.l && bad;
            sbq.push_back(w);
        end
    endtask

    task automatic drive_beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u, output int hc);
        bit r;
        bit ok;
        s_axis_tdata = d; s_axis_tkeep = k; s_axis_tlast = l; s_axis_tuser = u; s_axis_tvalid = 1'b1;
        ok = 0;
        hc = 0;
        for (int t = 0; t < 4000; t++) begin
            @(negedge axi_clk);
            r = s_axis_tready;
            @(posedge axi_clk);
            #1;
            if (r) begin
                ok = 1;
                hc = cyc;
                break;
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        if (!ok) check("beat_timeout", 64'd0, 64'd1);
    endtask

    // stop_after < 0 sends the whole frame; otherwise only that many data beats, no tlast.
    task automatic send_frame(input logic [31:0] sec, input logic [31:0] nsec, input logic [31:0] cap,
                              input int nbytes, input bit bad, input bit push, input int stop_after);
        int          hc;
        int          beats;
        logic [63:0] d;
        logic [7:0]  k;
        int          n;
        cur.delete();
        for (int i = 0; i < nbytes; i++) cur.push_back(8'($urandom_range(0, 255)));
        if (push) model_push(sec, nsec, cap, bad);
        drive_beat({nsec, sec}, 8'hFF, 1'b0, 1'b0, hc);
        drive_beat({32'hDEAD_BEEF, cap}, 8'hFF, 1'b0, 1'b0, hc);
        beat1_cyc = hc;
        beats = 0;
        for (int b = 0; b < nbytes; b += 8) begin
            if (stop_after >= 0 && beats >= stop_after) break;
            n = (nbytes - b > 8) ? 8 : nbytes - b;
            d = '0;
            for (int j = 0; j < n; j++) d[8*j +: 8] = cur[b+j];
            k = 8'((16'h1 << n) - 16'h1);
            drive_beat(d, k, (b + 8 >= nbytes), (b + 8 >= nbytes) && bad, hc);
            beats++;
        end
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 0;
        for (int t = 0; t < 20000; t++) begin
            @(negedge axi_clk);
            if (sbq.size() == 0 && !m_axis_tvalid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("drain_timeout", 64'(sbq.size()), 64'd0);
        repeat (2) @(posedge axi_clk);
        #1;
    endtask

    initial begin
        vec_t        vt[7];
        int          bc0, l0, w0, t0;
        int          hc;

        vt[0] = '{60,   60,   2,            5,         0, 0, 92,   12,  0};
        vt[1] = '{61,   61,   1,            0,         0, 0, 96,   12,  0};
        vt[2] = '{1514, 1514, 32'h12345678, 123456789, 0, 1, 1548, 194, 0};
        vt[3] = '{96,   100,  7,            7,         0, 1, 132,  16,  1};
        vt[4] = '{1,    1,    3,            1,         1, 0, 36,   5,   0};
        vt[5] = '{8,    8,    4,            2,         1, 1, 40,   5,   0};
        vt[6] = '{4,    4,    32'hFFFFFFFF, 999999999, 0, 0, 36,   5,   0};

        repeat (3) @(posedge axi_clk);
        #1 axi_rstn = 1'b1;
        @(negedge axi_clk);
        check("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_m_tlast_tuser", {m_axis_tlast, m_axis_tuser}, 64'd0);
        check("rst_m_tkeep", 64'(m_axis_tkeep), 64'd0);
        check("rst_length_error", 64'(length_error), 64'd0);
        check("rst_block_count", 64'(block_count), 64'd0);
        check("rst_s_tready", 64'(s_axis_tready), 64'd1);
        @(posedge axi_clk);
        #1;

        for (int v = 0; v < 7; v++) begin
            rand_rdy = vt[v].rnd;
            bc0 = block_count; l0 = lerr_cnt;
            send_frame(vt[v].sec, vt[v].nsec, vt[v].cap, vt[v].nbytes, vt[v].bad, 1, -1);
            wait_drain();
            rand_rdy = 0;
            check($sformatf("v%0d_block_count", v), 64'(block_count), 64'(bc0 + 1));
            check($sformatf("v%0d_length_error", v), 64'(lerr_cnt - l0), 64'(vt[v].exp_lerr));
            check($sformatf("v%0d_total", v), 64'(hdr[0][63:32]), 64'(vt[v].exp_total));
            check($sformatf("v%0d_words", v), 64'(blk_words), 64'(vt[v].exp_words));
            if (v == 0) begin
                check("v0_hdr0", hdr[0], 64'h0000005C_00000006);
                check("v0_hdr1", hdr[1], 64'h00000000_00000000);
                check("v0_hdr2", hdr[2], 64'h0000003C_77359405);
                check("v0_final_keep", 64'(fin_keep), 64'h0F);
                check("v0_final_low", 64'(fin_dat[31:0]), 64'h0000005C);
                check("v0_hdr0_latency", 64'(hdr0_cyc - beat1_cyc), 64'd0);
                check("v0_hdr1_latency", 64'(hdr1_cyc - beat1_cyc), 64'd1);
            end
            if (v == 1) begin
                check("v1_final_keep", 64'(fin_keep), 64'hFF);
                check("v1_bytes89_95", fin_dat, {32'h00000060, 24'h0, fin_dat[7:0]});
            end
            if (v == 4) check("v4_final_tuser", 64'(fin_user), 64'd1);
        end

        // Back-to-back 64-byte frames with the sink always ready.
        bc0 = block_count; w0 = words_seen; gap_bad = 0; chk_gap = 1;
        send_frame(10, 20, 64, 64, 0, 1, -1);
        send_frame(11, 21, 64, 64, 0, 1, -1);
        wait_drain();
        chk_gap = 0;
        check("b2b_block_count", 64'(block_count - bc0), 64'd2);
        check("b2b_words", 64'(words_seen - w0), 64'd24);
        check("b2b_data_gaps", 64'(gap_bad), 64'd0);

        // Runts: tlast on the timestamp beat, then on the length beat.
        bc0 = block_count; l0 = lerr_cnt; w0 = words_seen;
        drive_beat(64'h1, 8'hFF, 1'b1, 1'b0, hc);
        drive_beat(64'h2, 8'hFF, 1'b0, 1'b0, hc);
        drive_beat(64'd40, 8'hFF, 1'b1, 1'b0, hc);
        repeat (5) @(posedge axi_clk);
        #1;
        check("runt_length_error", 64'(lerr_cnt - l0), 64'd2);
        check("runt_no_output", 64'(words_seen - w0), 64'd0);
        check("runt_block_count", 64'(block_count), 64'(bc0));
        send_frame(5, 6, 20, 20, 0, 1, -1);
        wait_drain();
        check("post_runt_block_count", 64'(block_count), 64'(bc0 + 1));

        // Reset during DATA abandons the block.
        sb_en = 0;
        t0 = tlast_seen;
        send_frame(1, 1, 64, 64, 0, 0, 3);
        repeat (2) @(posedge axi_clk);
        #1 axi_rstn = 1'b0;
        repeat (2) @(posedge axi_clk);
        #1 axi_rstn = 1'b1;
        @(negedge axi_clk);
        check("rst_mid_no_tlast", 64'(tlast_seen - t0), 64'd0);
        check("rst_mid_block_count", 64'(block_count), 64'd0);
        check("rst_mid_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        sbq.delete();
        sb_en = 1;
        @(posedge axi_clk);
        #1;
        send_frame(9, 9, 64, 64, 0, 1, -1);
        wait_drain();
        check("rst_new_block_count", 64'(block_count), 64'd1);
        check("rst_new_words", 64'(blk_words), 64'd12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
